// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one data_ram port between m0 (CPU load/store) and m1 (DMA/debug loader).
// One transaction per grant: the winner's request is latched, held on the ram_* outputs, and completed with a one-cycle ack.
module data_ram_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_sel,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_sel,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [3:0]    ram_sel,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    grant,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic       last_owner;  // 0 = m0, 1 = m1; also identifies the owner during ACCESS/DONE
  logic [3:0] cnt;
  logic       pick_m1;

  assign fsm_state = state;

  // On a tie the master that did not win last time goes next.
  always_comb begin
    pick_m1 = m1_req && (!m0_req || !last_owner);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_sel    <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      grant      <= 2'b00;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            last_owner <= pick_m1;
            grant      <= pick_m1 ? 2'b10 : 2'b01;
            ram_ce     <= 1'b1;
            ram_we     <= pick_m1 ? m1_we    : m0_we;
            ram_sel    <= pick_m1 ? m1_sel   : m0_sel;
            ram_addr   <= pick_m1 ? m1_addr  : m0_addr;
            ram_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
            cnt        <= CNT_INIT;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // ram_we still holds the latched direction here.
            if (!ram_we) begin
              if (last_owner) m1_rdata <= ram_rdata;
              else            m0_rdata <= ram_rdata;
            end
            if (last_owner) m1_ack <= 1'b1;
            else            m0_ack <= 1'b1;
            ram_ce <= 1'b0;
            ram_we <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          grant  <= 2'b00;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus randomized concurrent traffic from both masters,
// checked by a scoreboard against a word-level shadow memory and a round-robin arbitration model.
module tb_data_ram_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int WAIT = 3;
  localparam int TMO  = 100;

  // Valid/ready: a master raises req with stable we/sel/addr/wdata and holds them until it sees its
  // one-cycle ack; it then drops req (or presents the next request) on the edge ending the ack cycle.

  logic          clk, rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [3:0]    m0_sel, m1_sel;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack;
  logic          ram_ce, ram_we;
  logic [3:0]    ram_sel;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [1:0]    grant, fsm_state;

  data_ram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .grant(grant), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and compare ----------------
  int checks = 0;
  int passes = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endfunction

  // ---------------- data_ram model (combinational read) ----------------
  logic [DW-1:0] mem [256];
  assign ram_rdata = mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t          exp_q0[$];
  exp_t          exp_q1[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_hold [2];

  // Monitor state
  int          ce_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_sel;
  logic [1:0]  cap_grant, prev_grant, exp_g;
  logic        p0, p1, arb_valid, last_m1, ack0_prev, ack1_prev;

  task automatic handle_ack(input int m);
    exp_t e;
    int   qs;
    qs = (m == 0) ? exp_q0.size() : exp_q1.size();
    check($sformatf("ack_expected_m%0d", m), 64'(qs != 0), 64'(1));
    if (qs != 0) begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("owner_m%0d", m), 64'(cap_grant), (m == 0) ? 64'(2'b01) : 64'(2'b10));
      check($sformatf("ram_addr_m%0d", m), 64'(cap_addr), 64'(e.addr));
      check($sformatf("ram_we_m%0d", m), 64'(cap_we), 64'(e.we));
      check($sformatf("ram_sel_m%0d", m), 64'(cap_sel), 64'(e.sel));
      if (e.we) check($sformatf("ram_wdata_m%0d", m), 64'(cap_wdata), 64'(e.wdata));
      check($sformatf("ce_cycles_m%0d", m), 64'(ce_cnt), 64'(WAIT));
      check($sformatf("rdata_m%0d", m), (m == 0) ? 64'(m0_rdata) : 64'(m1_rdata), 64'(e.rdata));
    end
    ce_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      ce_cnt    = 0;
      arb_valid = 1'b0;
      last_m1   = 1'b1;
      ack0_prev = 1'b0;
      ack1_prev = 1'b0;
    end else begin
      check("we_only_with_ce", 64'(ram_we && !ram_ce), 64'(0));
      // Round robin: a grant appears one cycle after an idle cycle that saw a request.
      if (arb_valid && prev_grant == 2'b00) begin
        if (p0 && p1)  exp_g = last_m1 ? 2'b01 : 2'b10;
        else if (p0)   exp_g = 2'b01;
        else if (p1)   exp_g = 2'b10;
        else           exp_g = 2'b00;
        check("arb_grant", 64'(grant), 64'(exp_g));
        if (exp_g != 2'b00) last_m1 = (exp_g == 2'b10);
      end
      if (ram_ce) begin
        if (ce_cnt == 0) begin
          cap_addr  = ram_addr;
          cap_we    = ram_we;
          cap_sel   = ram_sel;
          cap_wdata = ram_wdata;
          cap_grant = grant;
        end else begin
          check("ram_addr_stable", 64'(ram_addr), 64'(cap_addr));
        end
        ce_cnt++;
      end
      if (m0_ack) check("ack0_one_cycle", 64'(ack0_prev), 64'(0));
      if (m1_ack) check("ack1_one_cycle", 64'(ack1_prev), 64'(0));
      if (m0_ack && m1_ack) check("acks_exclusive", 64'(m0_ack && m1_ack), 64'(0));
      if (m0_ack) handle_ack(0);
      if (m1_ack) handle_ack(1);
      ack0_prev  = m0_ack;
      ack1_prev  = m1_ack;
      p0         = m0_req;
      p1         = m1_req;
      prev_grant = grant;
      arb_valid  = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int m, input logic req, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata; m0_req = req;
    end else begin
      m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; m1_req = req;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the ack cycle.
  task automatic issue(input int m, input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit mutate, input logic [31:0] mut_addr,
                       output int lat);
    exp_t       e;
    logic [7:0] idx;
    idx     = addr[9:2];
    e.addr  = addr;
    e.we    = we;
    e.sel   = sel;
    e.wdata = wdata;
    if (we) begin
      e.rdata = exp_hold[m];
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      e.rdata     = ref_mem[idx];
      exp_hold[m] = ref_mem[idx];
    end
    if (m == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    drive(m, 1'b1, we, sel, addr, wdata);
    lat = -1;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      if (mutate && ram_ce && grant == ((m == 0) ? 2'b01 : 2'b10))
        drive(m, 1'b1, we, sel, mut_addr, wdata);
      if ((m == 0) ? m0_ack : m1_ack) begin
        lat = c;
        break;
      end
    end
    check($sformatf("ack_seen_m%0d", m), 64'(lat >= 0), 64'(1));
    @(posedge clk);
    #1;
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_hold[0] = '0;
    exp_hold[1] = '0;
    rst = 1'b1;
  endtask

  task automatic random_traffic(input int m, input int n);
    int          lat, gap;
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  idx;
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      we   = 1'($urandom_range(0, 1));
      sel  = we ? 4'($urandom_range(1, 15)) : 4'hF;
      idx  = (m == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
      addr = {22'($urandom), idx, 2'b00};
      issue(m, we, sel, addr, $urandom, 1'b0, 32'h0, lat);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  int lat0, lat1, w;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4]     = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    exp_hold[0] = '0;
    exp_hold[1] = '0;

    // Reset state, sampled while reset is held.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_ce", 64'(ram_ce), 64'(0));
    check("rst_ram_we", 64'(ram_we), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_m0_ack", 64'(m0_ack), 64'(0));
    check("rst_m1_ack", 64'(m1_ack), 64'(0));
    check("rst_m0_rdata", 64'(m0_rdata), 64'(0));
    check("rst_m1_rdata", 64'(m1_rdata), 64'(0));
    check("rst_ram_addr", 64'(ram_addr), 64'(0));
    check("rst_ram_sel", 64'(ram_sel), 64'(0));
    check("rst_ram_wdata", 64'(ram_wdata), 64'(0));
    rst = 1'b1;

    // Single uncontested read.
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'h0, lat0);
    check("t1_latency", 64'(lat0), 64'(WAIT + 1));
    check("t1_rdata", 64'(m0_rdata), 64'(32'hDEADBEEF));

    // Simultaneous first requests after reset: m0 first, then m1.
    do_reset();
    fork
      issue(0, 1'b0, 4'hF, 32'h30, 32'h0, 1'b0, 32'h0, lat0);
      issue(1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0, 32'h0, lat1);
    join
    check("t2_m0_latency", 64'(lat0), 64'(WAIT + 1));
    check("t2_m1_latency", 64'(lat1), 64'(2 * WAIT + 3));
    fork
      for (int i = 0; i < 4; i++) issue(0, 1'b0, 4'hF, 32'(i * 4 + 64), 32'h0, 1'b0, 32'h0, lat0);
      for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'hF, 32'(i * 4 + 768), 32'h0, 1'b0, 32'h0, lat1);
    join

    // Partial write by m1, then read back.
    issue(1, 1'b1, 4'b0011, 32'h20, 32'h12345678, 1'b0, 32'h0, lat1);
    issue(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'h0, lat1);

    // Address changed mid-access must not reach the RAM; the follow-up request then does.
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'h44, lat0);
    issue(0, 1'b0, 4'hF, 32'h44, 32'h0, 1'b0, 32'h0, lat0);

    // Reset asserted mid-access: outputs fall without a clock edge, no ack.
    drive(0, 1'b1, 1'b0, 4'hF, 32'h50, 32'h0);
    w = 0;
    while (!ram_ce && w < TMO) begin
      @(negedge clk);
      w++;
    end
    check("t5_access_reached", 64'(ram_ce), 64'(1));
    rst = 1'b0;
    #1;
    check("t5_ce_async", 64'(ram_ce), 64'(0));
    check("t5_we_async", 64'(ram_we), 64'(0));
    check("t5_grant_async", 64'(grant), 64'(0));
    check("t5_no_ack", 64'(m0_ack), 64'(0));
    m0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_hold[0] = '0;
    exp_hold[1] = '0;
    fork
      issue(0, 1'b0, 4'hF, 32'h50, 32'h0, 1'b0, 32'h0, lat0);
      issue(1, 1'b0, 4'hF, 32'h204, 32'h0, 1'b0, 32'h0, lat1);
    join
    check("t5_m0_wins", 64'(lat0), 64'(WAIT + 1));
    check("t5_m1_second", 64'(lat1), 64'(2 * WAIT + 3));

    // Randomized concurrent traffic on disjoint address halves.
    fork
      random_traffic(0, 40);
      random_traffic(1, 40);
    join

    repeat (5) @(posedge clk);
    check("q0_drained", 64'(exp_q0.size()), 64'(0));
    check("q1_drained", 64'(exp_q1.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
